// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: steps a programmable layer table through LOAD/RUN/DRAIN/NEXT for the NN datapath
// Optional feature macro: NN_SEQ_TIMEOUT_EN (per-layer RUN cycle limit with sticky timeout_err)
// Ports: clk/reset (sync, active-high); start/abort/num_layers run control;
//        cfg_we/cfg_idx/cfg_nk/cfg_wbase/cfg_rbase/cfg_wrbase layer-table writes (ignored while busy);
//        ag_finished/ag_neuron_finished from the address generator;
//        ag_load + ag_nk/ag_wbase/ag_rbase/ag_wrbase to the address generator;
//        mac_en/mac_clr/res_we to the MAC/activation path; layer_idx/busy/done/timeout_err status.
module nn_layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int AW         = 8,
    parameter int PIPE_DEPTH = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            abort,
    input  logic [$clog2(NUM_LAYERS+1)-1:0] num_layers,
    input  logic                            cfg_we,
    input  logic [$clog2(NUM_LAYERS)-1:0]   cfg_idx,
    input  logic [AW-1:0]                   cfg_nk,
    input  logic [AW-1:0]                   cfg_wbase,
    input  logic [AW-1:0]                   cfg_rbase,
    input  logic [AW-1:0]                   cfg_wrbase,
    input  logic                            ag_finished,
    input  logic                            ag_neuron_finished,
    output logic                            ag_load,
    output logic [AW-1:0]                   ag_nk,
    output logic [AW-1:0]                   ag_wbase,
    output logic [AW-1:0]                   ag_rbase,
    output logic [AW-1:0]                   ag_wrbase,
    output logic                            mac_en,
    output logic                            mac_clr,
    output logic                            res_we,
    output logic [$clog2(NUM_LAYERS)-1:0]   layer_idx,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout_err
);
    localparam int LW = $clog2(NUM_LAYERS);
    localparam int NW = $clog2(NUM_LAYERS + 1);
    localparam int CW = $clog2(PIPE_DEPTH + 2);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_NEXT, S_DONE} state_t;

    state_t        r_state;
    logic [AW-1:0] r_tab_nk  [NUM_LAYERS];
    logic [AW-1:0] r_tab_wb  [NUM_LAYERS];
    logic [AW-1:0] r_tab_rb  [NUM_LAYERS];
    logic [AW-1:0] r_tab_wrb [NUM_LAYERS];
    logic [AW-1:0] r_ag_nk, r_ag_wb, r_ag_rb, r_ag_wrb;
    logic [NW-1:0] r_num;
    logic [LW-1:0] r_idx;
    logic [CW-1:0] r_dcnt;
    logic          w_load, w_last, w_tmo;

    // During LOAD the buses show the table entry directly; afterwards the captured copy holds them.
    assign w_load    = r_state == S_LOAD;
    assign ag_load   = w_load;
    assign ag_nk     = w_load ? r_tab_nk[r_idx]  : r_ag_nk;
    assign ag_wbase  = w_load ? r_tab_wb[r_idx]  : r_ag_wb;
    assign ag_rbase  = w_load ? r_tab_rb[r_idx]  : r_ag_rb;
    assign ag_wrbase = w_load ? r_tab_wrb[r_idx] : r_ag_wrb;
    assign mac_en    = r_state == S_RUN;
    assign res_we    = mac_en && ag_neuron_finished;
    assign mac_clr   = w_load || res_we;
    assign layer_idx = r_idx;
    assign busy      = r_state != S_IDLE && r_state != S_DONE;
    assign done      = r_state == S_DONE;
    // Last layer of the run, also capped at the table end so layer_idx never wraps.
    assign w_last    = (NW'(r_idx) + NW'(1) == r_num) || (r_idx == LW'(NUM_LAYERS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_num    <= '0;
            r_idx    <= '0;
            r_dcnt   <= '0;
            r_ag_nk  <= '0;
            r_ag_wb  <= '0;
            r_ag_rb  <= '0;
            r_ag_wrb <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_tab_nk[i]  <= '0;
                r_tab_wb[i]  <= '0;
                r_tab_rb[i]  <= '0;
                r_tab_wrb[i] <= '0;
            end
        end else begin
            if (cfg_we && !busy) begin
                r_tab_nk[cfg_idx]  <= cfg_nk;
                r_tab_wb[cfg_idx]  <= cfg_wbase;
                r_tab_rb[cfg_idx]  <= cfg_rbase;
                r_tab_wrb[cfg_idx] <= cfg_wrbase;
            end
            if (w_load) begin
                r_ag_nk  <= r_tab_nk[r_idx];
                r_ag_wb  <= r_tab_wb[r_idx];
                r_ag_rb  <= r_tab_rb[r_idx];
                r_ag_wrb <= r_tab_wrb[r_idx];
            end
            if (abort && r_state != S_IDLE) r_state <= S_IDLE;
            else begin
                case (r_state)
                    S_IDLE: if (start && num_layers != '0) begin
                        r_num   <= num_layers;
                        r_idx   <= '0;
                        r_state <= S_LOAD;
                    end
                    S_LOAD: r_state <= (r_tab_nk[r_idx] == '0) ? S_NEXT : S_RUN;
                    S_RUN: if (ag_finished) begin
                        r_dcnt  <= CW'(PIPE_DEPTH);
                        r_state <= S_DRAIN;
                    end else if (w_tmo) r_state <= S_IDLE;
                    // A count of 0 or 1 both leave now, so PIPE_DEPTH=0 still spends one cycle here.
                    S_DRAIN: if (r_dcnt <= CW'(1)) r_state <= S_NEXT;
                             else r_dcnt <= r_dcnt - 1'b1;
                    S_NEXT: if (w_last) r_state <= S_DONE;
                    else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_LOAD;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef NN_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_terr;
    assign w_tmo       = r_tcnt == TW'(TIMEOUT - 1);
    assign timeout_err = r_terr;
    // The counter idles at zero outside RUN, so every RUN entry starts counting from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
            r_terr <= 1'b0;
        end else begin
            r_tcnt <= mac_en ? r_tcnt + 1'b1 : '0;
            if (r_state == S_IDLE && start && num_layers != '0) r_terr <= 1'b0;
            else if (mac_en && w_tmo && !ag_finished && !abort) r_terr <= 1'b1;
        end
    end
`else
    assign w_tmo       = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: scoreboard bench for nn_layer_sequencer
module tb_nn_layer_sequencer;
    logic       clk = 1'b0;
    logic       reset, start, abort, cfg_we, ag_finished, ag_neuron_finished;
    logic [2:0] num_layers;
    logic [1:0] cfg_idx;
    logic [7:0] cfg_nk, cfg_wbase, cfg_rbase, cfg_wrbase;
    logic       ag_load, mac_en, mac_clr, res_we, busy, done, timeout_err;
    logic [7:0] ag_nk, ag_wbase, ag_rbase, ag_wrbase;
    logic [1:0] layer_idx;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_done = 0;
    int          mac_cnt [4];
    logic [33:0] q_load [$];
    logic [1:0]  q_res [$];

    nn_layer_sequencer #(.NUM_LAYERS(4), .AW(8), .PIPE_DEPTH(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_layers(num_layers),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_nk(cfg_nk), .cfg_wbase(cfg_wbase),
        .cfg_rbase(cfg_rbase), .cfg_wrbase(cfg_wrbase), .ag_finished(ag_finished),
        .ag_neuron_finished(ag_neuron_finished), .ag_load(ag_load), .ag_nk(ag_nk),
        .ag_wbase(ag_wbase), .ag_rbase(ag_rbase), .ag_wrbase(ag_wrbase), .mac_en(mac_en),
        .mac_clr(mac_clr), .res_we(res_we), .layer_idx(layer_idx), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Output monitor: pops expected events as the DUT produces them.
    always @(negedge clk) begin
        if (!reset) begin
            if (ag_load) begin
                n_cmp++;
                if (q_load.size() == 0) begin
                    n_bad++;
                    $display("FAIL ag_load_unexpected: got %h, required no load", {layer_idx, ag_nk, ag_wbase, ag_rbase, ag_wrbase});
                end else begin
                    logic [33:0] e;
                    e = q_load.pop_front();
                    if ({layer_idx, ag_nk, ag_wbase, ag_rbase, ag_wrbase} !== e) begin
                        n_bad++;
                        $display("FAIL ag_load_bus: got %h, required %h", {layer_idx, ag_nk, ag_wbase, ag_rbase, ag_wrbase}, e);
                    end
                end
                if (mac_clr !== 1'b1) begin
                    n_bad++;
                    $display("FAIL load_mac_clr: got %b, required 1", mac_clr);
                end
            end
            if (res_we) begin
                n_cmp++;
                if (q_res.size() == 0) begin
                    n_bad++;
                    $display("FAIL res_we_unexpected: layer %0d, required none", layer_idx);
                end else begin
                    logic [1:0] e;
                    e = q_res.pop_front();
                    if (layer_idx !== e || mac_clr !== 1'b1) begin
                        n_bad++;
                        $display("FAIL res_we: layer %0d clr %b, required layer %0d clr 1", layer_idx, mac_clr, e);
                    end
                end
            end
            if (mac_en) mac_cnt[layer_idx]++;
            if (done) begin
                n_cmp++;
                if (exp_done == 0 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL done_pulse: done with %0d expected, busy %b, required expected>0 busy 0", exp_done, busy);
                end
                if (exp_done > 0) exp_done--;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] i, input logic [7:0] nk, wb, rb, wrb);
        cfg_we = 1'b1; cfg_idx = i; cfg_nk = nk; cfg_wbase = wb; cfg_rbase = rb; cfg_wrbase = wrb;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic push_load(input logic [1:0] i, input logic [7:0] nk, wb, rb, wrb);
        q_load.push_back({i, nk, wb, rb, wrb});
    endtask

    task automatic push_res(input logic [1:0] i, input int n);
        for (int k = 0; k < n; k++) q_res.push_back(i);
    endtask

    task automatic do_start(input logic [2:0] n);
        start = 1'b1; num_layers = n;
        tick;
        start = 1'b0; num_layers = '0;
    endtask

    task automatic clear_mac_cnt;
        for (int k = 0; k < 4; k++) mac_cnt[k] = 0;
    endtask

    // Waits for LOAD, then emulates the address generator: one neuron every 3 RUN cycles,
    // with ag_finished on the last neuron's boundary. Returns in the first DRAIN cycle.
    task automatic run_layer(input int nk);
        int w;
        w = 0;
        while (!ag_load && w < 20) begin tick; w++; end
        if (!ag_load) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_ag_load: got no load in %0d cycles, required a load", w);
        end
        tick;
        for (int n = 0; n < nk; n++)
            for (int c = 0; c < 3; c++) begin
                ag_neuron_finished = (c == 2);
                ag_finished = (c == 2) && (n == nk - 1);
                tick;
            end
        ag_neuron_finished = 1'b0; ag_finished = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 60) begin tick; cyc++; end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_done: got no done in %0d cycles, required done", cyc);
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (q_load.size() != 0 || q_res.size() != 0 || exp_done != 0) begin
            n_bad++;
            $display("FAIL %s_pending: loads %0d res %0d done %0d, required 0 0 0", name, q_load.size(), q_res.size(), exp_done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        n_cmp++;
        if ({ag_load, mac_en, mac_clr, res_we, busy, done, timeout_err, layer_idx, ag_nk, ag_wbase, ag_rbase, ag_wrbase} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required 0", {ag_load, mac_en, mac_clr, res_we, busy, done, timeout_err, layer_idx, ag_nk, ag_wbase, ag_rbase, ag_wrbase});
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_two_layers;
        int cyc;
        cfg_write(2'd0, 8'd3, 8'h00, 8'h10, 8'h20);
        cfg_write(2'd1, 8'd2, 8'h30, 8'h20, 8'h40);
        push_load(2'd0, 8'd3, 8'h00, 8'h10, 8'h20);
        push_load(2'd1, 8'd2, 8'h30, 8'h20, 8'h40);
        push_res(2'd0, 3); push_res(2'd1, 2);
        exp_done = 1;
        do_start(3'd2);
        n_cmp++;
        if (busy !== 1'b1 || layer_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL start_busy: busy %b idx %0d, required 1 0", busy, layer_idx);
        end
        run_layer(3);
        run_layer(2);
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 3 || layer_idx !== 2'd1) begin
            n_bad++;
            $display("FAIL two_done_timing: cycles %0d idx %0d, required 3 1", cyc, layer_idx);
        end
        tick;
        n_cmp++;
        if (ag_nk !== 8'd2 || ag_wrbase !== 8'h40 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ag_hold: nk %0d wr %h busy %b, required 2 40 0", ag_nk, ag_wrbase, busy);
        end
        check_drained("two_layers");
    endtask

    task automatic test_skip_layer;
        int cyc;
        cfg_write(2'd0, 8'd2, 8'h01, 8'h02, 8'h03);
        cfg_write(2'd1, 8'd0, 8'h04, 8'h05, 8'h06);
        cfg_write(2'd2, 8'd1, 8'h07, 8'h08, 8'h09);
        push_load(2'd0, 8'd2, 8'h01, 8'h02, 8'h03);
        push_load(2'd1, 8'd0, 8'h04, 8'h05, 8'h06);
        push_load(2'd2, 8'd1, 8'h07, 8'h08, 8'h09);
        push_res(2'd0, 2); push_res(2'd2, 1);
        exp_done = 1;
        clear_mac_cnt();
        do_start(3'd3);
        run_layer(2);
        run_layer(0);
        run_layer(1);
        wait_done(cyc);
        tick;
        n_cmp++;
        if (mac_cnt[0] != 6 || mac_cnt[1] != 0 || mac_cnt[2] != 3) begin
            n_bad++;
            $display("FAIL skip_mac_en: counts %0d/%0d/%0d, required 6/0/3", mac_cnt[0], mac_cnt[1], mac_cnt[2]);
        end
        check_drained("skip");
    endtask

    task automatic test_drain;
        cfg_write(2'd0, 8'd1, 8'hA1, 8'hA2, 8'hA3);
        push_load(2'd0, 8'd1, 8'hA1, 8'hA2, 8'hA3);
        push_res(2'd0, 1);
        exp_done = 1;
        do_start(3'd1);
        run_layer(1);
        n_cmp++;
        if (mac_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL drain1: mac_en %b busy %b done %b, required 0 1 0", mac_en, busy, done);
        end
        tick;
        n_cmp++;
        if (mac_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL drain2: mac_en %b busy %b done %b, required 0 1 0", mac_en, busy, done);
        end
        tick;
        n_cmp++;
        if (mac_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || ag_load !== 1'b0) begin
            n_bad++;
            $display("FAIL next_cycle: mac_en %b busy %b done %b load %b, required 0 1 0 0", mac_en, busy, done, ag_load);
        end
        tick;
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_after_next: got %b, required 1", done);
        end
        do_start(3'd1);
        n_cmp++;
        if (busy !== 1'b0 || ag_load !== 1'b0) begin
            n_bad++;
            $display("FAIL start_in_done: busy %b load %b, required 0 0", busy, ag_load);
        end
        tick;
        check_drained("drain");
    endtask

    task automatic test_abort;
        int cyc;
        cfg_write(2'd0, 8'd3, 8'h11, 8'h12, 8'h13);
        push_load(2'd0, 8'd3, 8'h11, 8'h12, 8'h13);
        do_start(3'd1);
        tick; tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || mac_en !== 1'b0 || ag_load !== 1'b0 || res_we !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: busy %b mac_en %b load %b res %b, required 0 0 0 0", busy, mac_en, ag_load, res_we);
        end
        for (int k = 0; k < 5; k++) tick;
        push_load(2'd0, 8'd3, 8'h11, 8'h12, 8'h13);
        push_res(2'd0, 3);
        exp_done = 1;
        do_start(3'd1);
        n_cmp++;
        if (layer_idx !== 2'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rerun_idx: idx %0d busy %b, required 0 1", layer_idx, busy);
        end
        run_layer(3);
        wait_done(cyc);
        tick;
        check_drained("abort");
    endtask

    task automatic test_cfg_busy;
        int cyc;
        cfg_write(2'd0, 8'd1, 8'h21, 8'h22, 8'h23);
        for (int r = 0; r < 2; r++) begin
            push_load(2'd0, 8'd1, 8'h21, 8'h22, 8'h23);
            push_res(2'd0, 1);
            exp_done = 1;
            do_start(3'd1);
            run_layer(1);
            if (r == 0) cfg_write(2'd0, 8'd5, 8'hEE, 8'hEE, 8'hEE);
            wait_done(cyc);
            tick;
        end
        check_drained("cfg_busy");
        do_start(3'd0);
        n_cmp++;
        if (busy !== 1'b0 || ag_load !== 1'b0) begin
            n_bad++;
            $display("FAIL start_zero: busy %b load %b, required 0 0", busy, ag_load);
        end
        tick; tick; tick;
        check_drained("start_zero");
    endtask

    task automatic test_reset_mid;
        int cyc;
        cfg_write(2'd0, 8'd3, 8'h51, 8'h52, 8'h53);
        push_load(2'd0, 8'd3, 8'h51, 8'h52, 8'h53);
        do_start(3'd1);
        tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_cmp++;
        if ({busy, mac_en, ag_load, done, layer_idx, ag_nk, ag_wbase} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got %h, required 0", {busy, mac_en, ag_load, done, layer_idx, ag_nk, ag_wbase});
        end
        push_load(2'd0, 8'd0, 8'h00, 8'h00, 8'h00);
        exp_done = 1;
        do_start(3'd1);
        run_layer(0);
        wait_done(cyc);
        tick;
        check_drained("reset_mid");
    endtask

`ifdef NN_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int cyc;
        cfg_write(2'd0, 8'd3, 8'h61, 8'h62, 8'h63);
        push_load(2'd0, 8'd3, 8'h61, 8'h62, 8'h63);
        clear_mac_cnt();
        do_start(3'd1);
        tick;
        cyc = 0;
        while (busy && cyc < 30) begin tick; cyc++; end
        n_cmp++;
        if (cyc != 8 || timeout_err !== 1'b1 || mac_cnt[0] != 8) begin
            n_bad++;
            $display("FAIL timeout: cycles %0d err %b mac %0d, required 8 1 8", cyc, timeout_err, mac_cnt[0]);
        end
        tick;
        push_load(2'd0, 8'd3, 8'h61, 8'h62, 8'h63);
        do_start(3'd1);
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: got %b, required 0", timeout_err);
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tick;
        check_drained("timeout");
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_layers = '0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_nk = '0; cfg_wbase = '0; cfg_rbase = '0; cfg_wrbase = '0;
        ag_finished = 1'b0; ag_neuron_finished = 1'b0;
        clear_mac_cnt();
        test_reset();
        test_two_layers();
        test_skip_layer();
        test_drain();
        test_abort();
        test_cfg_busy();
        test_reset_mid();
`ifdef NN_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Top-level controller for the neural-network inference datapath. Steps through a programmable table of layers.
- For each layer it:
  - loads the address generator with that layer's neuron count and base addresses;
  - enables the MAC while addresses stream;
  - commits one neuron result per neuron-boundary pulse;
  - drains the pipeline before moving to the next layer.
- Sits between the host/config interface and the address-generator/MAC/activation datapath.

Parameters:
- NUM_LAYERS, 4, depth of the layer table (max layers per run).
- AW, 8, address and neuron-count width.
- PIPE_DEPTH, 2, cycles from the last MAC enable to the last result write landing in neuron memory.
- TIMEOUT, 1023, max cycles allowed in RUN per layer (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin run; sampled only in IDLE.
- abort  in  1  abandon run; return to IDLE.
- num_layers  in  $clog2(NUM_LAYERS+1)  layers to execute; sampled with start.
- cfg_we  in  1  layer-table write strobe.
- cfg_idx  in  $clog2(NUM_LAYERS)  table entry to write.
- cfg_nk  in  AW  neuron count of the entry.
- cfg_wbase, cfg_rbase, cfg_wrbase  in  AW each  weight-read, neuron-read and neuron-write base addresses.
- ag_finished  in  1  address generator: whole layer issued.
- ag_neuron_finished  in  1  address generator: last input of the current neuron issued.
- ag_load  out  1  one-cycle load pulse to the address generator.
- ag_nk, ag_wbase, ag_rbase, ag_wrbase  out  AW each  configuration presented with ag_load.
- mac_en  out  1  accumulate enable.
- mac_clr  out  1  clear accumulator.
- res_we  out  1  write the activated neuron result.
- layer_idx  out  $clog2(NUM_LAYERS)  current layer.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run ends normally.
- timeout_err  out  1  sticky error flag (optional feature only).

Behaviour:
- Reset: state=IDLE, layer_idx=0, every table entry zeroed. All outputs 0, including ag_* buses.
- Table writes:
  - cfg_we is accepted only when busy=0; the entry updates on the next edge.
  - cfg_we while busy=1 is ignored and the table is unchanged.
- IDLE:
  - start=1 with num_layers>0: latch num_layers, set layer_idx=0, go to LOAD next cycle. busy rises on that same edge.
  - start=1 with num_layers=0: no state change, no done.
- LOAD (1 cycle):
  - ag_load=1, mac_clr=1; ag_* driven from table[layer_idx].
  - Go to RUN, or to NEXT if entry nk==0 (layer skipped; no mac_en, no res_we).
  - ag_* buses hold their value until the next LOAD.
- RUN:
  - mac_en=1 every cycle.
  - In a cycle with ag_neuron_finished=1: res_we=1 and mac_clr=1 in that same cycle. The next neuron's accumulation starts from zero on the following cycle.
  - ag_finished=1: go to DRAIN. If ag_neuron_finished is also high that cycle, res_we still fires.
- DRAIN:
  - mac_en=0; down-counter loaded with PIPE_DEPTH on entry.
  - Go to NEXT when the counter reaches 0, after exactly PIPE_DEPTH cycles.
  - PIPE_DEPTH=0 means a 1-cycle pass-through.
- NEXT (1 cycle):
  - If layer_idx==num_layers-1: go to DONE.
  - Else increment layer_idx and go to LOAD.
  - layer_idx is never incremented past NUM_LAYERS-1 (no wrap).
- DONE (1 cycle): done=1, busy=0; go to IDLE. A start in the DONE cycle is ignored.
- Abort:
  - abort=1 in any non-IDLE state: go to IDLE on the next edge.
  - mac_en, res_we, ag_load deassert at that edge; no done pulse.
  - abort has priority over all other transitions.
  - abort in IDLE has no effect.
- Reset mid-run: identical to power-on reset. The table is cleared.
- Throughput: per layer, 1 + RUN cycles + PIPE_DEPTH + 1 cycles.

Optional Feature:
- Macro: NN_SEQ_TIMEOUT_EN.
- Defined:
  - A RUN cycle counter clears on entry to RUN.
  - If it reaches TIMEOUT without ag_finished: set timeout_err (sticky until reset or next accepted start), drop mac_en, go to IDLE. No done pulse.
- Undefined: no counter; timeout_err tied to 0; RUN waits indefinitely.

Test Plan:
- Program 2 layers (nk=3, bases 0x00/0x10/0x20 and nk=2, 0x30/0x20/0x40), num_layers=2, start; emulate ag_neuron_finished every 3 cycles -> ag_load pulses twice with the matching buses, res_we count 3 then 2, done one cycle after the second NEXT, layer_idx 0->1.
- Entry nk=0 between two valid layers, num_layers=3 -> middle layer: ag_load, then NEXT with no mac_en/res_we; the other layers run normally.
- ag_finished and ag_neuron_finished high in the same cycle -> res_we=1 that cycle, then exactly PIPE_DEPTH=2 cycles with mac_en=0 before NEXT.
- Abort during RUN of layer 0 -> IDLE next cycle, busy=0, no done. A following start reruns from layer_idx=0.
- cfg_we while busy -> table unchanged (check the next run's ag_* values). start with num_layers=0 -> stays IDLE.
- With NN_SEQ_TIMEOUT_EN and TIMEOUT=8, ag_finished never asserted -> timeout_err=1 after 8 RUN cycles, IDLE, no done. Next start clears timeout_err.
